uart_parity_rx: RTL and testbench

- Serial UART receiver: recovers one byte per frame from the `rx` line and checks odd parity and the stop bit.
- Output is a byte plus a one-cycle `finished` strobe, with parity and framing error flags.
- Sits at the far end of the serial link from the team's transmitter and replaces the bare loopback receiver in the link bench.
- Frame: start (0), 8 data bits LSB first, odd-parity bit, stop (1).

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_bit_timer.sv | 36 +++
 rtl/uart_parity_rx.sv | 150 +++++++++++++++
 tb/tb_uart_parity_rx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   uart_rx_state_t : receiver FSM state encoding
//   UART_DATA_BITS  : payload bits per frame
//   UART_FRAME_BITS : bits on the wire per frame (start + data + [parity] + stop)
//   odd_parity()    : parity bit that makes the nine-bit total odd
// Build option: UART_RX_PARITY_EN adds the parity bit to the frame.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } uart_rx_state_t;

  localparam int UART_DATA_BITS = 8;

`ifdef UART_RX_PARITY_EN
  localparam int UART_FRAME_BITS = 11;
`else
  localparam int UART_FRAME_BITS = 10;
`endif

  function automatic logic odd_parity(input logic [7:0] b);
    return ~(^b);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-period counter for the UART receiver.
//   clk, rst_n : clock, async active-low reset
//   clear      : hold the count at 0
//   half_mode  : terminal count is CLKS_PER_BIT/2 instead of CLKS_PER_BIT
//   sample     : one-cycle pulse on the terminal count; the count wraps to 0
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic half_mode,
  output logic sample
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] HALF_TC = W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [W-1:0] FULL_TC = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] count;

  always_comb begin
    sample = !clear && (count == (half_mode ? HALF_TC : FULL_TC));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || sample) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_parity_rx.sv
// uart_parity_rx: UART receiver, 8 data bits LSB first, optional odd parity, one stop bit.
//   clk, rst_n : clock, async active-low reset
//   rx         : serial line (idle high, asynchronous)
//   data       : last received byte, held until the next frame completes
//   finished   : one-cycle pulse per completed frame
//   err        : parity error of the last frame (0 when parity is not built in)
//   frame_err  : stop bit of the last frame was low
//   busy       : frame in progress
// Build option: UART_RX_PARITY_EN enables the parity bit and the err flag.
//
// state     | meaning
// IDLE      | line idle, waiting for a low level
// START     | confirming the start bit at its centre
// DATA      | sampling the 8 data bits at their centres
// PARITY    | sampling the parity bit
// STOP      | sampling the stop bit
// WAIT_IDLE | stop bit was low; wait for the line to return high
module uart_parity_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       finished,
  output logic       err,
  output logic       frame_err,
  output logic       busy
);

  uart_rx_state_t state, state_next;

  logic       rx_meta, rx_s;
  logic       sample, tmr_clear, tmr_half;
  logic [7:0] shift;
  logic [2:0] bit_idx;
  logic       stop_pend;
  logic       stop_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (tmr_clear),
    .half_mode (tmr_half),
    .sample    (sample)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (!rx_s) state_next = START;
      START:     if (sample) state_next = rx_s ? IDLE : DATA;
      DATA: begin
        if (sample && bit_idx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY:    if (sample) state_next = STOP;
`endif
      STOP:      if (sample) state_next = rx_s ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx_s) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // stop_pend covers the cycle between the stop sample and the finished
  // strobe, so busy drops exactly when finished rises.
  always_comb begin
    tmr_clear = (state == IDLE) || (state == WAIT_IDLE);
    tmr_half  = (state == START);
    busy      = (state != IDLE) || stop_pend;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift     <= '0;
      bit_idx   <= '0;
      stop_pend <= 1'b0;
      stop_bit  <= 1'b1;
      data      <= '0;
      finished  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      finished  <= stop_pend;
      stop_pend <= 1'b0;
      if (state == START) begin
        bit_idx <= '0;
      end
      if (state == DATA && sample) begin
        shift   <= {rx_s, shift[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      if (state == STOP && sample) begin
        stop_pend <= 1'b1;
        stop_bit  <= rx_s;
      end
      if (stop_pend) begin
        data      <= shift;
        frame_err <= ~stop_bit;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic err_pend;

  // err_pend holds the parity result until the frame's finished cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pend <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (state == PARITY && sample) begin
        err_pend <= (rx_s != odd_parity(shift));
      end
      if (stop_pend) begin
        err <= err_pend;
      end
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_parity_rx.sv
module tb_uart_parity_rx;

  localparam int CPB = 4;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int FB = 11;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int FB = 10;
`endif
  localparam int LAT = 2 + CPB / 2 + (FB - 1) * CPB + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       finished, err, frame_err, busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] data;
    logic       err;
    logic       ferr;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   fin_cyc[$];
  logic prev_fin = 1'b0;

  uart_parity_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (data),
    .finished  (finished),
    .err       (err),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && finished) begin
      check("no_double_finished", int'(prev_fin), 0);
      fin_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_finished", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("data", int'(data), int'(e.data));
        check("err", int'(err), int'(e.err));
        check("frame_err", int'(frame_err), int'(e.ferr));
        check("finished_cycle", cyc, e.cyc);
      end
    end
    prev_fin = finished;
  end

  task automatic hold_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    hold_bit(1'b1);
    for (int i = 1; i < n; i++) hold_bit(1'b1);
  endtask

  // Called at #1 after a posedge; returns at #1 after a posedge.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop,
                            input logic exp_err, input logic exp_ferr);
    exp_t e;
    e.data = d;
    e.err  = PAR_EN ? exp_err : 1'b0;
    e.ferr = exp_ferr;
    e.cyc  = cyc + 1 + LAT;
    exp_q.push_back(e);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(d[i]);
    if (PAR_EN) hold_bit(p);
    hold_bit(stop);
  endtask

  initial begin
    bit seen_busy;
    int g;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", int'(data), 0);
    check("rst_finished", int'(finished), 0);
    check("rst_err", int'(err), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    idle_bits(2);

    // good odd parity: 0xC1 has 3 ones, p=0
    send_frame(8'hC1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_bits(2);
    // 0x41 has 2 ones: p=0 gives an even total -> error, p=1 -> clean
    send_frame(8'h41, 1'b0, 1'b1, 1'b1, 1'b0);
    idle_bits(2);
    send_frame(8'h41, 1'b1, 1'b1, 1'b0, 1'b0);
    idle_bits(2);

    // framing error followed by a long break
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b1);
    rx = 1'b0;
    repeat (4 * CPB) @(posedge clk);
    #1;
    check("busy_in_break", int'(busy), 1);
    repeat (16 * CPB) @(posedge clk);
    #1;
    check("busy_end_break", int'(busy), 1);
    idle_bits(2);
    check("busy_after_break", int'(busy), 0);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
    idle_bits(2);

    // one-clock glitch while idle
    rx = 1'b0;
    @(posedge clk);
    #1;
    rx = 1'b1;
    seen_busy = 1'b0;
    for (int i = 0; i < CPB / 2 + 4; i++) begin
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
    end
    check("glitch_busy_seen", int'(seen_busy), 1);
    check("glitch_busy_cleared", int'(busy), 0);
    check("glitch_data_held", int'(data), 8'h3C);
    @(posedge clk);
    #1;
    idle_bits(2);

    // reset in the middle of data bit 4
    hold_bit(1'b0);
    for (int i = 0; i < 4; i++) hold_bit(1'b1);
    rx = 1'b0;
    repeat (CPB / 2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_data", int'(data), 0);
    check("midrst_finished", int'(finished), 0);
    check("midrst_err", int'(err), 0);
    check("midrst_frame_err", int'(frame_err), 0);
    check("midrst_busy", int'(busy), 0);
    rx = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_bits(2);
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
    idle_bits(2);

    // back-to-back, no idle gap
    g = fin_cyc.size();
    send_frame(8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
    idle_bits(3);
    if (fin_cyc.size() >= g + 2)
      check("b2b_gap", fin_cyc[g+1] - fin_cyc[g], FB * CPB);
    else
      check("b2b_two_pulses", fin_cyc.size() - g, 2);

    for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
